// File: rtl/spi_flash_read.sv
// SPI mode-0 READ (0x03 + 24-bit address) of len bytes, streamed out one byte per po_flag pulse.
// po_flag is registered one cycle after tx_ready is seen in WAIT; SCK is parked low while the consumer stalls.
module spi_flash_read #(
  parameter int SCK_DIV = 4,
  parameter int CS_HOLD = 4
) (
  input  logic        sclk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [23:0] addr,
  input  logic [15:0] len,
  output logic        busy,
  output logic        done,
  output logic [7:0]  po_data,
  output logic        po_flag,
  input  logic        tx_ready,
  output logic        cs_n,
  output logic        sck,
  output logic        mosi,
  input  logic        miso
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_CMD, S_RD, S_WAIT, S_HOLD, S_DONE} state_t;

  localparam logic [7:0]  CMD_READ  = 8'h03;
  localparam logic [15:0] DIV_LAST  = 16'(SCK_DIV - 1);
  localparam logic [15:0] HOLD_LAST = 16'(CS_HOLD - 1);

  state_t      state_q;
  logic [15:0] div_q;
  logic [15:0] rem_q;
  logic [4:0]  bit_q;
  logic [30:0] sh_q;
  logic [7:0]  rx_q;
  logic [7:0]  pod_q;
  logic        busy_q, done_q, flag_q, cs_n_q, sck_q, mosi_q;
  logic        half_end;

  assign half_end = (div_q == DIV_LAST);

  assign busy    = busy_q;
  assign done    = done_q;
  assign po_data = pod_q;
  assign po_flag = flag_q;
  assign cs_n    = cs_n_q;
  assign sck     = sck_q;
  assign mosi    = mosi_q;

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      rem_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      rx_q    <= '0;
      pod_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      flag_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
    end else begin
      flag_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            rem_q  <= len;
            sh_q   <= {CMD_READ[6:0], addr};
            div_q  <= '0;
            bit_q  <= '0;
            if (len == 16'd0) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              cs_n_q  <= 1'b0;
              mosi_q  <= CMD_READ[7];
              state_q <= S_SETUP;
            end
          end
        end
        S_SETUP: begin
          if (half_end) begin
            div_q   <= '0;
            state_q <= S_CMD;
          end else begin
            div_q <= div_q + 16'd1;
          end
        end
        S_CMD: begin
          if (half_end) begin
            div_q <= '0;
            if (!sck_q) begin
              sck_q <= 1'b1;
            end else begin
              // mosi only changes on the falling edge so the flash sees stable data on the rise
              sck_q <= 1'b0;
              if (bit_q == 5'd31) begin
                mosi_q  <= 1'b0;
                bit_q   <= '0;
                state_q <= S_RD;
              end else begin
                bit_q  <= bit_q + 5'd1;
                mosi_q <= sh_q[30];
                sh_q   <= {sh_q[29:0], 1'b0};
              end
            end
          end else begin
            div_q <= div_q + 16'd1;
          end
        end
        S_RD: begin
          if (half_end) begin
            div_q <= '0;
            if (!sck_q) begin
              sck_q <= 1'b1;
              rx_q  <= {rx_q[6:0], miso};
            end else begin
              sck_q <= 1'b0;
              if (bit_q == 5'd7) begin
                bit_q   <= '0;
                state_q <= S_WAIT;
              end else begin
                bit_q <= bit_q + 5'd1;
              end
            end
          end else begin
            div_q <= div_q + 16'd1;
          end
        end
        S_WAIT: begin
          if (tx_ready) begin
            pod_q  <= rx_q;
            flag_q <= 1'b1;
            rem_q  <= rem_q - 16'd1;
            if (rem_q == 16'd1) begin
              cs_n_q  <= 1'b1;
              div_q   <= '0;
              state_q <= S_HOLD;
            end else begin
              // the WAIT cycle already counts toward the next low phase
              div_q   <= 16'd1;
              state_q <= S_RD;
            end
          end
        end
        S_HOLD: begin
          if (div_q == HOLD_LAST) begin
            div_q   <= '0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            div_q <= div_q + 16'd1;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_read.sv
// Randomized bench for spi_flash_read with a behavioural SPI flash and transfer-level expectations.
module tb_spi_flash_read;
  localparam int DIV  = 4;
  localparam int HOLD = 4;

  logic        sclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [23:0] addr = '0;
  logic [15:0] len = '0;
  logic        tx_ready = 1'b1;
  logic        miso = 1'b0;
  logic        busy, done, po_flag, cs_n, sck, mosi;
  logic [7:0]  po_data;

  spi_flash_read #(.SCK_DIV(DIV), .CS_HOLD(HOLD)) dut (
    .sclk(sclk), .rst_n(rst_n), .start(start), .addr(addr), .len(len),
    .busy(busy), .done(done), .po_data(po_data), .po_flag(po_flag),
    .tx_ready(tx_ready), .cs_n(cs_n), .sck(sck), .mosi(mosi), .miso(miso)
  );

  always #5 sclk = ~sclk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // flash contents (low address byte selects the entry) and line observations
  logic [7:0]  mem [0:255];
  logic [7:0]  po_log [0:4095];
  logic [31:0] cmd = '0;
  int tot_rise = 0, sess_rise = 0, phase_len = 0, since_cs = 0, first_rise_dly = 0;
  int lo_ne = 0, lo_short = 0, hi_bad = 0, po_n = 0, done_n = 0, cs_fall_n = 0;
  int stall_flags = 0, sck_cs_bad = 0;
  bit first_lo = 1'b1, cs_prev = 1'b1, sck_prev = 1'b0, stall = 1'b0;

  always @(negedge sclk) begin
    int k;
    logic [7:0] idx;
    logic [7:0] b;
    phase_len++;
    since_cs++;
    if (cs_prev && !cs_n) begin
      cs_fall_n++;
      sess_rise = 0;
      since_cs  = 0;
      cmd       = '0;
      first_lo  = 1'b1;
    end
    if (!cs_n && sck && !sck_prev) begin
      tot_rise++;
      sess_rise++;
      if (sess_rise == 1) first_rise_dly = since_cs;
      if (sess_rise <= 32) cmd = {cmd[30:0], mosi};
      if (!first_lo) begin
        if (phase_len != DIV) lo_ne++;
        if (phase_len < DIV) lo_short++;
      end
      first_lo  = 1'b0;
      phase_len = 0;
    end
    if (!cs_n && !sck && sck_prev) begin
      if (phase_len != DIV) hi_bad++;
      phase_len = 0;
      if (sess_rise >= 32) begin
        k    = sess_rise - 32;
        idx  = cmd[7:0] + 8'(k / 8);
        b    = mem[idx];
        miso = b[7 - (k % 8)];
      end
    end
    if (cs_n && sck) sck_cs_bad++;
    if (po_flag) begin
      po_log[po_n % 4096] = po_data;
      po_n++;
      if (stall) stall_flags++;
    end
    if (done) done_n++;
    cs_prev  = cs_n;
    sck_prev = sck;
  end

  task automatic step();
    @(posedge sclk);
    #1;
  endtask

  task automatic pulse_start(input logic [23:0] a, input logic [15:0] l);
    addr  = a;
    len   = l;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // mode 0: tx_ready held high, 1: random tx_ready, 2: extra start pulse mid-command
  task automatic run_xfer(input logic [23:0] a, input logic [15:0] l, input int mode);
    int r0, p0, d0, cyc, exp_r;
    logic [7:0] ix;
    r0 = tot_rise; p0 = po_n; d0 = done_n;
    pulse_start(a, l);
    cyc = 0;
    while (done_n == d0 && cyc < 20000) begin
      if (mode == 1) tx_ready = ($urandom_range(0, 3) != 0);
      if (mode == 2 && cyc == 50) begin
        addr = 24'hFFFFFF; len = 16'd9; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      step();
      cyc++;
    end
    start = 1'b0;
    tx_ready = 1'b1;
    chk("done_seen", 32'(cyc < 20000), 1);
    exp_r = (l == 0) ? 0 : 32 + 8 * int'(l);
    chk("sck_rises", tot_rise - r0, exp_r);
    chk("byte_count", po_n - p0, 32'(l));
    if (l != 0) chk("mosi_cmd", cmd, {8'h03, a});
    for (int i = 0; i < int'(l); i++) begin
      ix = a[7:0] + 8'(i);
      chk("byte_data", po_log[(p0 + i) % 4096], mem[ix]);
    end
    chk("idle_busy", busy, 0);
    chk("idle_cs_n", cs_n, 1);
  endtask

  initial begin
    int r0, p0, d0, c0, s0, l0, cyc, nbad;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h45] = 8'hA5; mem[8'h46] = 8'h5A; mem[8'h47] = 8'hFF;

    step(); step();
    chk("rst_cs_n", cs_n, 1);
    chk("rst_sck", sck, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_po_flag", po_flag, 0);
    chk("rst_po_data", po_data, 0);
    rst_n = 1'b1;
    step();

    // basic read, exact SCK timing
    l0 = lo_ne;
    run_xfer(24'h012345, 16'd3, 0);
    chk("first_rise_dly", first_rise_dly, 2 * DIV);
    chk("low_phase_exact", lo_ne - l0, 0);
    chk("po_data_kept", po_data, 8'hFF);

    // consumer stall after the first byte
    r0 = tot_rise; p0 = po_n; d0 = done_n; s0 = stall_flags;
    pulse_start(24'h012345, 16'd3);
    cyc = 0;
    while (po_n == p0 && cyc < 2000) begin step(); cyc++; end
    chk("byte1_seen", 32'(cyc < 2000), 1);
    tx_ready = 1'b0;
    stall = 1'b1;
    nbad = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (i >= 80 && (sck || cs_n)) nbad++;
    end
    chk("stall_lines", nbad, 0);
    tx_ready = 1'b1;
    stall = 1'b0;
    step();
    chk("stall_no_flag", stall_flags - s0, 0);
    chk("byte2_flag", po_flag, 1);
    chk("byte2_data", po_data, 8'h5A);
    cyc = 0;
    while (done_n == d0 && cyc < 2000) begin step(); cyc++; end
    chk("stall_done", 32'(cyc < 2000), 1);
    chk("stall_rises", tot_rise - r0, 56);
    chk("stall_count", po_n - p0, 3);
    chk("stall_byte3", po_log[(p0 + 2) % 4096], 8'hFF);

    // zero length
    r0 = tot_rise; p0 = po_n; c0 = cs_fall_n;
    pulse_start(24'h000100, 16'd0);
    chk("len0_done", done, 1);
    chk("len0_busy", busy, 1);
    step();
    chk("len0_done_end", done, 0);
    chk("len0_busy_end", busy, 0);
    chk("len0_cs", cs_fall_n - c0, 0);
    chk("len0_sck", tot_rise - r0, 0);
    chk("len0_flag", po_n - p0, 0);

    // start ignored while busy
    run_xfer(24'($urandom), 16'd5, 2);

    // reset during byte 2
    p0 = po_n; d0 = done_n;
    pulse_start(24'($urandom), 16'd4);
    cyc = 0;
    while (po_n == p0 && cyc < 2000) begin step(); cyc++; end
    repeat (20) step();
    rst_n = 1'b0;
    #1;
    chk("abort_cs_n", cs_n, 1);
    chk("abort_sck", sck, 0);
    chk("abort_busy", busy, 0);
    repeat (3) step();
    rst_n = 1'b1;
    repeat (30) step();
    chk("abort_no_done", done_n - d0, 0);
    chk("abort_bytes", po_n - p0, 1);
    run_xfer(24'($urandom), 16'd1, 0);

    // randomized transfers with random consumer readiness
    run_xfer(24'hFFFFFE, 16'd4, 1);
    for (int t = 0; t < 6; t++) run_xfer(24'($urandom), 16'($urandom_range(1, 6)), 1);

    chk("high_phase_len", hi_bad, 0);
    chk("low_phase_min", lo_short, 0);
    chk("sck_while_cs_high", sck_cs_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
